// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the time-shared binary-to-BCD converter.
// The optional macro LEADING_ZERO_BLANK_EN is consumed by bcd_multi_converter.
package bcd_conv_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, STORE, COMMIT} state_t;

   localparam logic [3:0] BLANK_NIB = 4'hF;
   localparam logic [3:0] ERR_NIB   = 4'hE;

   // Overflow threshold 10**n as an exact 64-bit constant.
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

endpackage

// File: rtl/bcd_multi_converter_if.sv
// Request/result bundle between the game number registers and the converter.
interface bcd_multi_converter_if #(
   parameter int NUM_CH = 4,
   parameter int IN_W   = 10,
   parameter int DIGITS = 3
) ();
   logic                         start;
   logic [NUM_CH*IN_W-1:0]       nums;
   logic [NUM_CH-1:0]            valid;
   logic                         busy;
   logic                         done;
   logic [NUM_CH*DIGITS*4-1:0]   digits;
   logic [NUM_CH-1:0]            ovf;

   modport master (output start, nums, valid, input  busy, done, digits, ovf);
   modport slave  (input  start, nums, valid, output busy, done, digits, ovf);
endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift the next input bit in.
module bcd_dabble_step #(
   parameter int DIGITS = 3
) (
   input  logic [DIGITS*4-1:0] i_bcd,
   input  logic                i_bit,
   output logic [DIGITS*4-1:0] o_bcd
);
   logic [DIGITS*4-1:0] w_adj;

   // NOTE: assigning a default before the loop keeps every bit driven on every path, so no latch is inferred.
   always_comb begin
      w_adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         w_adj[i*4 +: 4] = (i_bcd[i*4 +: 4] >= 4'd5) ? i_bcd[i*4 +: 4] + 4'd3 : i_bcd[i*4 +: 4];
      end
   end

   assign o_bcd = {w_adj[DIGITS*4-2:0], i_bit};

endmodule

// File: rtl/bcd_multi_converter.sv
// Time-shared binary-to-BCD converter: one dabble engine walks all channels, results commit atomically.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits of valid, in-range channels.
module bcd_multi_converter
   import bcd_conv_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int IN_W   = 10,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   bcd_multi_converter_if.slave  bus
);
   localparam int              DW        = DIGITS * 4;
   localparam int              CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int              BIT_W     = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(IN_W - 1);
   localparam logic [63:0]      OVF_LIMIT = pow10(DIGITS);

   state_t             r_state, w_next;
   logic [CH_W-1:0]    r_ch, w_next_ch;
   logic [BIT_W-1:0]   r_bit;
   logic [IN_W-1:0]    r_nums [NUM_CH];
   logic [NUM_CH-1:0]  r_valid;
   logic [IN_W-1:0]    r_shreg;
   logic [DW-1:0]      r_bcd, w_bcd_next, w_shown, w_store_nibs;
   logic               w_store_ovf, w_lead_zero;
   logic [DW-1:0]      r_sh_dig [NUM_CH];
   logic [NUM_CH-1:0]  r_sh_ovf;
   logic [NUM_CH*DW-1:0] r_digits;
   logic [NUM_CH-1:0]  r_ovf;
   logic               r_done;

   bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
      .i_bcd (r_bcd),
      .i_bit (r_shreg[IN_W-1]),
      .o_bcd (w_bcd_next)
   );

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = SHIFT;
         SHIFT:   if (r_bit == LAST_BIT) w_next = STORE;
         STORE:   w_next = (r_ch == LAST_CH) ? COMMIT : SHIFT;
         COMMIT:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_next_ch = (r_ch == LAST_CH) ? '0 : r_ch + 1'b1;

   // Channel result as written to the shadow during STORE.
   always_comb begin
      w_shown     = r_bcd;
      w_lead_zero = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (w_lead_zero && (r_bcd[i*4 +: 4] == 4'h0)) w_shown[i*4 +: 4] = BLANK_NIB;
         else                                          w_lead_zero      = 1'b0;
      end
`endif
      w_store_nibs = w_shown;
      w_store_ovf  = 1'b0;
      if (!r_valid[r_ch]) begin
         w_store_nibs = {DIGITS{BLANK_NIB}};
      end else if (64'(r_nums[r_ch]) >= OVF_LIMIT) begin
         w_store_nibs = {DIGITS{ERR_NIB}};
         w_store_ovf  = 1'b1;
      end
   end

   // NOTE: the captured channel values need no reset; they are always written before STORE reads them.
   always_ff @(posedge clk) begin
      if (r_state == IDLE && bus.start) begin
         for (int i = 0; i < NUM_CH; i++) r_nums[i] <= bus.nums[i*IN_W +: IN_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ch     <= '0;
         r_bit    <= '0;
         r_valid  <= '0;
         r_shreg  <= '0;
         r_bcd    <= '0;
         for (int i = 0; i < NUM_CH; i++) r_sh_dig[i] <= {DIGITS{BLANK_NIB}};
         r_sh_ovf <= '0;
         r_digits <= {(NUM_CH*DIGITS){BLANK_NIB}};
         r_ovf    <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= (r_state == COMMIT);
         case (r_state)
            IDLE: if (bus.start) begin
               r_valid <= bus.valid;
               r_ch    <= '0;
               r_bit   <= '0;
               r_bcd   <= '0;
               r_shreg <= bus.nums[IN_W-1:0];
            end
            SHIFT: begin
               r_bcd   <= w_bcd_next;
               r_shreg <= r_shreg << 1;
               r_bit   <= (r_bit == LAST_BIT) ? '0 : r_bit + 1'b1;
            end
            STORE: begin
               r_sh_dig[r_ch] <= w_store_nibs;
               r_sh_ovf[r_ch] <= w_store_ovf;
               r_ch           <= w_next_ch;
               r_bcd          <= '0;
               r_shreg        <= r_nums[w_next_ch];
            end
            COMMIT: begin
               for (int i = 0; i < NUM_CH; i++) r_digits[i*DW +: DW] <= r_sh_dig[i];
               r_ovf <= r_sh_ovf;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = (r_state != IDLE);
   assign bus.done   = r_done;
   assign bus.digits = r_digits;
   assign bus.ovf    = r_ovf;

endmodule

// File: tb/tb_bcd_multi_converter.sv
// Scoreboard bench: stimulus pushes expected results, negedge monitors pop on every done pulse.
`timescale 1ns/1ps
module tb_bcd_multi_converter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   bcd_multi_converter_if #(.NUM_CH(4), .IN_W(10), .DIGITS(3)) u_if ();
   bcd_multi_converter #(.NUM_CH(4), .IN_W(10), .DIGITS(3)) u_dut (
      .clk (clk), .rst (rst), .bus (u_if.slave));

   bcd_multi_converter_if #(.NUM_CH(2), .IN_W(14), .DIGITS(5)) u_if2 ();
   bcd_multi_converter #(.NUM_CH(2), .IN_W(14), .DIGITS(5)) u_dut2 (
      .clk (clk), .rst (rst), .bus (u_if2.slave));

   typedef struct packed { logic [47:0] dig; logic [3:0] ovf; } exp_t;
   typedef struct packed { logic [39:0] dig; logic [1:0] ovf; } exp2_t;
   exp_t  exp_q  [$];
   exp2_t exp2_q [$];

   int    checks   = 0;
   int    failures = 0;
   string cur_test = "reset";

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [47:0] E1  = 48'h999F24FF7FF0;
   localparam logic [47:0] E2  = 48'hFFFF24FFFFF0;
   localparam logic [47:0] E3  = 48'h500F10EEEEEE;
   localparam logic [47:0] E4  = 48'hFF1FF2FF3FF4;
   localparam logic [47:0] E4C = 48'h100F99FF9999;
   localparam logic [47:0] E5  = 48'hFF6F60600998;
   localparam logic [47:0] E6  = 48'hFF5F40FF0123;
   localparam logic [39:0] F1  = 40'h16383FFFF9;
   localparam logic [39:0] F2  = 40'hFFFFFFFFF0;
`else
   localparam logic [47:0] E1  = 48'h999024007000;
   localparam logic [47:0] E2  = 48'hFFF024FFF000;
   localparam logic [47:0] E3  = 48'h500010EEEEEE;
   localparam logic [47:0] E4  = 48'h001002003004;
   localparam logic [47:0] E4C = 48'h100099009999;
   localparam logic [47:0] E5  = 48'h006060600998;
   localparam logic [47:0] E6  = 48'h005040000123;
   localparam logic [39:0] F1  = 40'h1638300009;
   localparam logic [39:0] F2  = 40'hFFFFF00000;
`endif

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s/%s: got %h expected %h", cur_test, name, act, req);
      end
   endtask

   // Monitors: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && u_if.done) begin
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s/unexpected_done: got done=1 expected no done", cur_test);
         end else begin
            e = exp_q.pop_front();
            check("digits", 64'(u_if.digits), 64'(e.dig));
            check("ovf", 64'(u_if.ovf), 64'(e.ovf));
         end
      end
   end

   always @(negedge clk) begin
      exp2_t e;
      if (!rst && u_if2.done) begin
         if (exp2_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s/unexpected_done2: got done=1 expected no done", cur_test);
         end else begin
            e = exp2_q.pop_front();
            check("digits2", 64'(u_if2.digits), 64'(e.dig));
            check("ovf2", 64'(u_if2.ovf), 64'(e.ovf));
         end
      end
   end

   // Called #1 after an edge while idle; returns #1 after the accept edge.
   task automatic issue(input logic [39:0] n, input logic [3:0] v,
                        input logic [47:0] d, input logic [3:0] o);
      u_if.nums  = n;
      u_if.valid = v;
      u_if.start = 1'b1;
      exp_q.push_back('{dig: d, ovf: o});
      @(posedge clk); #1;
      u_if.start = 1'b0;
      u_if.nums  = 40'({$urandom(), $urandom()});
      u_if.valid = 4'($urandom());
      check("busy_rise", 64'(u_if.busy), 64'd1);
   endtask

   // Counts busy cycles, optionally pulsing start at two busy cycles; returns in the done cycle.
   task automatic wait_done(input int ign_a, input int ign_b, output int cyc);
      cyc = 0;
      while (u_if.busy && cyc < 200) begin
         cyc++;
         u_if.start = (cyc == ign_a || cyc == ign_b);
         @(posedge clk); #1;
         u_if.start = 1'b0;
      end
      check("latency", 64'(cyc), 64'd45);
      check("done_pulse", 64'(u_if.done), 64'd1);
   endtask

   task automatic run(input logic [39:0] n, input logic [3:0] v,
                      input logic [47:0] d, input logic [3:0] o);
      int cyc;
      issue(n, v, d, o);
      wait_done(-1, -1, cyc);
      @(posedge clk); #1;
      check("done_one_cycle", 64'(u_if.done), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      u_if.start = 1'b0;  u_if.nums = '0;  u_if.valid = '0;
      u_if2.start = 1'b0; u_if2.nums = '0; u_if2.valid = '0;
      #1 rst = 1'b1;
      #1;
      check("rst_digits", 64'(u_if.digits), 64'hFFFF_FFFF_FFFF);
      check("rst_ovf", 64'(u_if.ovf), 64'd0);
      check("rst_busy", 64'(u_if.busy), 64'd0);
      check("rst_done", 64'(u_if.done), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;

      cur_test = "t1_all_valid";
      run({10'd999, 10'd24, 10'd7, 10'd0}, 4'hF, E1, 4'b0000);

      cur_test = "t2_masked";
      run({10'd999, 10'd24, 10'd7, 10'd0}, 4'b0101, E2, 4'b0000);

      cur_test = "t3_overflow";
      run({10'd500, 10'd10, 10'd1023, 10'd1000}, 4'hF, E3, 4'b0011);

      cur_test = "t4_ignore_start";
      issue({10'd1, 10'd2, 10'd3, 10'd4}, 4'hF, E4, 4'b0000);
      wait_done(3, 20, cyc);
      issue({10'd100, 10'd99, 10'd9, 10'd999}, 4'hF, E4C, 4'b0000);
      check("done_one_cycle", 64'(u_if.done), 64'd0);
      wait_done(-1, -1, cyc);
      @(posedge clk); #1;

      cur_test = "t5_reset_abort";
      issue({10'd555, 10'd555, 10'd555, 10'd555}, 4'hF, E1, 4'b0000);
      repeat (29) @(posedge clk);
      #1 rst = 1'b1;
      void'(exp_q.pop_back());
      #1;
      check("abort_digits", 64'(u_if.digits), 64'hFFFF_FFFF_FFFF);
      check("abort_ovf", 64'(u_if.ovf), 64'd0);
      check("abort_busy", 64'(u_if.busy), 64'd0);
      check("abort_done", 64'(u_if.done), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("idle_after_abort", 64'(u_if.busy), 64'd0);
      run({10'd6, 10'd60, 10'd600, 10'd998}, 4'hF, E5, 4'b0000);

      cur_test = "t6_leading_zero";
      run({10'd5, 10'd40, 10'd0, 10'd123}, 4'hF, E6, 4'b0000);

      cur_test = "t7_wide";
      u_if2.nums = {14'd16383, 14'd9}; u_if2.valid = 2'b11; u_if2.start = 1'b1;
      exp2_q.push_back('{dig: F1, ovf: 2'b00});
      @(posedge clk); #1 u_if2.start = 1'b0; u_if2.nums = '0;
      cyc = 0;
      while (u_if2.busy && cyc < 200) begin cyc++; @(posedge clk); #1; end
      check("latency2", 64'(cyc), 64'd31);
      @(posedge clk); #1;
      u_if2.nums = {14'd10000, 14'd0}; u_if2.valid = 2'b01; u_if2.start = 1'b1;
      exp2_q.push_back('{dig: F2, ovf: 2'b00});
      @(posedge clk); #1 u_if2.start = 1'b0;
      cyc = 0;
      while (u_if2.busy && cyc < 200) begin cyc++; @(posedge clk); #1; end
      check("latency2b", 64'(cyc), 64'd31);

      repeat (3) @(posedge clk);
      #1;
      cur_test = "end";
      check("queue_drained", 64'(exp_q.size() + exp2_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
